// File: rtl/omsp_spm_req_seq.sv
// omsp_spm_req_seq
// ----------------
// Sequences one SPM protect/unprotect request from the execution unit into the
// SPM control update interface.
//
// The flow is IDLE -> CHECK -> ISSUE -> WAIT -> DONE. Requests that fail
// CHECK skip ISSUE and WAIT and go straight to DONE. The layout arguments and
// the enable bit are captured once, at accept, and stay stable until the next
// accept. The array must acknowledge within MAX_WAIT cycles of WAIT. If it
// does not, the request completes with a timeout status.
//
// Optional feature: define SPM_REQ_ARGCHECK_EN to enable a local layout sanity
// check on protect requests. A request fails the check when either range is
// empty or inverted, or when the public and secret ranges overlap. Such a
// request is rejected in CHECK and never reaches the array.

module omsp_spm_req_seq #(
  parameter int unsigned MAX_WAIT = 8  // WAIT cycles before timeout, 1..255
) (
  input  logic        mclk,
  input  logic        reset_n,
  // execution-unit request side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_enable,
  input  logic [15:0] r12,
  input  logic [15:0] r13,
  input  logic [15:0] r14,
  input  logic [15:0] r15,
  // SPM array side
  input  logic        spm_free,
  output logic        spm_update,
  output logic        spm_enable,
  output logic [15:0] spm_r12,
  output logic [15:0] spm_r13,
  output logic [15:0] spm_r14,
  output logic [15:0] spm_r15,
  input  logic        spm_ack,
  input  logic        spm_err,
  // completion side
  output logic        done,
  output logic [1:0]  status,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_REJECT  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_NOFREE  = 2'b11;

  // Last counter value seen in WAIT. The counter is cleared in ISSUE and the
  // FSM leaves WAIT here, so the 8-bit counter can never wrap.
  localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  status_q, status_d;
  logic        update_q;
  logic        done_q;
  logic        enable_q;
  logic [15:0] r12_q, r13_q, r14_q, r15_q;
  logic        accept;
  logic        arg_bad;

  assign req_ready = (state_q == S_IDLE);
  assign busy      = ~req_ready;
  assign accept    = req_valid & req_ready;

`ifdef SPM_REQ_ARGCHECK_EN
  // Protect layouts must have non-empty ranges that do not overlap. Unprotect
  // requests carry no layout, so they are never rejected here.
  assign arg_bad = enable_q & ((r13_q <= r12_q) |
                               (r15_q <= r14_q) |
                               ((r12_q < r15_q) & (r14_q < r13_q)));
`else
  assign arg_bad = 1'b0;
`endif

  // Next-state and status decision for the request sequence.
  always_comb begin
    // NOTE: every variable gets a default before the case. Without it, any
    // path that skips an assignment would infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_CHECK;
          status_d = ST_OK;
        end
      end
      S_CHECK: begin
        if (enable_q & ~spm_free) begin
          state_d  = S_DONE;
          status_d = ST_NOFREE;
        end else if (arg_bad) begin
          state_d  = S_DONE;
          status_d = ST_REJECT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // An ack on the last WAIT cycle takes priority over the timeout.
        if (spm_ack) begin
          state_d  = S_DONE;
          status_d = spm_err ? ST_REJECT : ST_OK;
        end else if (cnt_q == LAST_CNT) begin
          state_d  = S_DONE;
          status_d = ST_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter, status and the registered single-cycle strobes.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      status_q <= ST_OK;
      update_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments. All flops then
      // sample the values from before the edge, whatever the statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      update_q <= (state_d == S_ISSUE);
      done_q   <= (state_d == S_DONE);
    end
  end

  // Capture the request arguments on accept. They hold until the next accept.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: these plain data registers are reset anyway, because they drive
      // outputs whose reset value must be 0.
      enable_q <= 1'b0;
      r12_q    <= 16'h0000;
      r13_q    <= 16'h0000;
      r14_q    <= 16'h0000;
      r15_q    <= 16'h0000;
    end else if (accept) begin
      enable_q <= req_enable;
      r12_q    <= r12;
      r13_q    <= r13;
      r14_q    <= r14;
      r15_q    <= r15;
    end
  end

  assign spm_update = update_q;
  assign spm_enable = enable_q;
  assign spm_r12    = r12_q;
  assign spm_r13    = r13_q;
  assign spm_r14    = r14_q;
  assign spm_r15    = r15_q;
  assign done       = done_q;
  assign status     = status_q;

endmodule

// File: tb/tb_omsp_spm_req_seq.sv
// Testbench for omsp_spm_req_seq.
// Built with MAX_WAIT = 4. Expectations for layout-check vectors follow
// SPM_REQ_ARGCHECK_EN.
// Cycle numbering: cycle 0 is the accept cycle (N). Cycle c is N+c. Inputs
// are driven and outputs sampled on the falling edge.

module tb_omsp_spm_req_seq;

  localparam int MW = 4;

`ifdef SPM_REQ_ARGCHECK_EN
  localparam bit ARGCHK = 1'b1;
`else
  localparam bit ARGCHK = 1'b0;
`endif

  logic        mclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_enable = 1'b0;
  logic [15:0] r12 = '0, r13 = '0, r14 = '0, r15 = '0;
  logic        spm_free = 1'b0;
  logic        spm_update;
  logic        spm_enable;
  logic [15:0] spm_r12, spm_r13, spm_r14, spm_r15;
  logic        spm_ack = 1'b0;
  logic        spm_err = 1'b0;
  logic        done;
  logic [1:0]  status;
  logic        busy;

  always #5 mclk = ~mclk;

  omsp_spm_req_seq #(.MAX_WAIT(MW)) dut (
    .mclk(mclk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_enable(req_enable),
    .r12(r12), .r13(r13), .r14(r14), .r15(r15),
    .spm_free(spm_free), .spm_update(spm_update), .spm_enable(spm_enable),
    .spm_r12(spm_r12), .spm_r13(spm_r13), .spm_r14(spm_r14), .spm_r15(spm_r15),
    .spm_ack(spm_ack), .spm_err(spm_err),
    .done(done), .status(status), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One request with its stimulus and hand-computed expectations.
  // The ack is high in cycles ack_lo..ack_hi. ack_hi < 0 means no ack at all.
  typedef struct {
    string       name;
    logic        en;
    logic [15:0] a12, a13, a14, a15;
    logic        free;
    int          ack_lo, ack_hi;
    logic        err;
    bit          toggle;    // wiggle req_valid/arguments while busy
    int          exp_upd;   // number of spm_update pulses
    int          exp_done;  // cycle of the done pulse
    logic [1:0]  exp_st;
  } vec_t;

  function automatic vec_t mk(string name, logic en, logic [15:0] a12, logic [15:0] a13,
                              logic [15:0] a14, logic [15:0] a15, logic free,
                              int ack_lo, int ack_hi, logic err, bit toggle,
                              int exp_upd, int exp_done, logic [1:0] exp_st);
    vec_t v;
    v.name = name; v.en = en; v.a12 = a12; v.a13 = a13; v.a14 = a14; v.a15 = a15;
    v.free = free; v.ack_lo = ack_lo; v.ack_hi = ack_hi; v.err = err; v.toggle = toggle;
    v.exp_upd = exp_upd; v.exp_done = exp_done; v.exp_st = exp_st;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int upd_cnt  = 0;
    int upd_cyc  = -1;
    int done_cyc = -1;
    @(negedge mclk);
    check({v.name, ".ready_before"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_enable = v.en;
    r12 = v.a12; r13 = v.a13; r14 = v.a14; r15 = v.a15;
    spm_free = v.free;
    spm_err  = v.err;
    spm_ack  = (v.ack_hi >= 0) && (v.ack_lo <= 0);
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      @(negedge mclk);
      if (c == 1) begin
        check({v.name, ".busy_after_accept"}, 32'(busy), 32'd1);
        check({v.name, ".ready_after_accept"}, 32'(req_ready), 32'd0);
      end
      if (spm_update) begin
        upd_cnt++;
        upd_cyc = c;
      end
      if (done) done_cyc = c;
      if (v.toggle) begin
        check({v.name, ".r12_stable"}, 32'(spm_r12), 32'(v.a12));
        check({v.name, ".r15_stable"}, 32'(spm_r15), 32'(v.a15));
        check({v.name, ".en_stable"}, 32'(spm_enable), 32'(v.en));
      end
      if (v.toggle && c < v.exp_done) begin
        req_valid  = c[0];
        req_enable = ~v.en;
        r12 = ~v.a12; r13 = ~v.a13; r14 = ~v.a14; r15 = ~v.a15;
      end else begin
        req_valid = 1'b0;
      end
      spm_ack = (v.ack_hi >= 0) && (c >= v.ack_lo) && (c <= v.ack_hi);
    end
    spm_ack   = 1'b0;
    req_valid = 1'b0;
    check({v.name, ".done_cycle"}, 32'(done_cyc), 32'(v.exp_done));
    check({v.name, ".status"}, 32'(status), 32'(v.exp_st));
    check({v.name, ".update_count"}, 32'(upd_cnt), 32'(v.exp_upd));
    check({v.name, ".update_cycle"}, 32'(upd_cyc), (v.exp_upd > 0) ? 32'd2 : 32'hFFFF_FFFF);
    check({v.name, ".spm_r13"}, 32'(spm_r13), 32'(v.a13));
    check({v.name, ".spm_enable"}, 32'(spm_enable), 32'(v.en));
    // In the cycle after done: back in IDLE, pulse gone, status held.
    @(negedge mclk);
    check({v.name, ".done_one_cycle"}, 32'(done), 32'd0);
    check({v.name, ".idle_ready"}, 32'(req_ready), 32'd1);
    check({v.name, ".idle_busy"}, 32'(busy), 32'd0);
    check({v.name, ".status_held"}, 32'(status), 32'(v.exp_st));
  endtask

  // Start a protect request that is never acked, then reset in cycle at_c.
  task automatic run_reset(input string name, input int at_c);
    int n_done = 0;
    int n_upd  = 0;
    @(negedge mclk);
    req_valid = 1'b1; req_enable = 1'b1;
    r12 = 16'h8000; r13 = 16'h8100; r14 = 16'h0200; r15 = 16'h0280;
    spm_free = 1'b1; spm_ack = 1'b0; spm_err = 1'b0;
    for (int c = 1; c <= at_c; c++) begin
      @(negedge mclk);
      req_valid = 1'b0;
    end
    if (at_c == 2) check({name, ".update_before_reset"}, 32'(spm_update), 32'd1);
    check({name, ".busy_before_reset"}, 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check({name, ".busy_in_reset"}, 32'(busy), 32'd0);
    check({name, ".ready_in_reset"}, 32'(req_ready), 32'd1);
    check({name, ".update_in_reset"}, 32'(spm_update), 32'd0);
    check({name, ".done_in_reset"}, 32'(done), 32'd0);
    check({name, ".r13_in_reset"}, 32'(spm_r13), 32'd0);
    @(negedge mclk);
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge mclk);
      if (done) n_done++;
      if (spm_update) n_upd++;
    end
    check({name, ".no_done_after_release"}, 32'(n_done), 32'd0);
    check({name, ".no_update_after_release"}, 32'(n_upd), 32'd0);
    check({name, ".ready_after_release"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    // Expectations for vectors whose outcome depends on the layout check.
    int          bad_upd  = ARGCHK ? 0 : 1;
    int          bad_done = ARGCHK ? 2 : 4;
    logic [1:0]  bad_st   = ARGCHK ? 2'b01 : 2'b00;

    //                name               en   r12      r13      r14      r15      free lo hi err tog upd done st
    vecs.push_back(mk("prot_ok",         1, 16'h8000, 16'h8100, 16'h0200, 16'h0280, 1,  5, 5, 0, 0, 1, 6, 2'b00));
    vecs.push_back(mk("prot_nofree",     1, 16'h8000, 16'h8100, 16'h0200, 16'h0280, 0,  0,-1, 0, 0, 0, 2, 2'b11));
    vecs.push_back(mk("unprot_nofree",   0, 16'h8000, 16'h8100, 16'h0200, 16'h0280, 0,  3, 3, 0, 0, 1, 4, 2'b00));
    vecs.push_back(mk("r13_le_r12",      1, 16'h8100, 16'h8000, 16'h0200, 16'h0280, 1,  3, 3, 0, 0, bad_upd, bad_done, bad_st));
    vecs.push_back(mk("timeout",         1, 16'h8000, 16'h8100, 16'h0200, 16'h0280, 1,  0,-1, 0, 0, 1, 7, 2'b10));
    vecs.push_back(mk("ack_last_wait",   1, 16'h8000, 16'h8100, 16'h0200, 16'h0280, 1,  6, 6, 0, 0, 1, 7, 2'b00));
    vecs.push_back(mk("err_last_wait",   1, 16'h8000, 16'h8100, 16'h0200, 16'h0280, 1,  6, 6, 1, 0, 1, 7, 2'b01));
    vecs.push_back(mk("ack_err",         1, 16'h8000, 16'h8100, 16'h0200, 16'h0280, 1,  3, 3, 1, 0, 1, 4, 2'b01));
    vecs.push_back(mk("overlap",         1, 16'h1000, 16'h2000, 16'h1800, 16'h2800, 1,  3, 3, 0, 0, bad_upd, bad_done, bad_st));
    vecs.push_back(mk("r15_eq_r14",      1, 16'h8000, 16'h8100, 16'h0300, 16'h0300, 1,  3, 3, 0, 0, bad_upd, bad_done, bad_st));
    vecs.push_back(mk("unprot_badargs",  0, 16'h8100, 16'h8000, 16'h0300, 16'h0300, 0,  3, 3, 0, 0, 1, 4, 2'b00));
    vecs.push_back(mk("adjacent",        1, 16'h1000, 16'h2000, 16'h2000, 16'h3000, 1,  4, 4, 0, 0, 1, 5, 2'b00));
    vecs.push_back(mk("ack_held_early",  1, 16'h8000, 16'h8100, 16'h0200, 16'h0280, 1,  0, 3, 0, 0, 1, 4, 2'b00));
    vecs.push_back(mk("busy_toggle",     1, 16'h4000, 16'h4100, 16'h0400, 16'h0480, 1,  5, 5, 0, 1, 1, 6, 2'b00));

    // Reset values.
    repeat (2) @(negedge mclk);
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.spm_update", 32'(spm_update), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.status", 32'(status), 32'd0);
    check("rst.spm_enable", 32'(spm_enable), 32'd0);
    check("rst.spm_r12", 32'(spm_r12), 32'd0);
    reset_n = 1'b1;
    @(negedge mclk);
    check("rst.ready_after_release", 32'(req_ready), 32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    run_reset("rst_in_wait", 4);
    run_reset("rst_in_issue", 2);
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
